ctrlsoc_flash_arb: RTL
======================

Name: ctrlsoc_flash_arb

Overview:
- Two-requester arbiter in front of the QSPI flash read engine (the valid/ready/addr/rdata continuous-read port).
- Port 0 is CPU instruction/data fetch; port 1 is the flash-to-SPRAM/mlaccel DMA.
- Preserves flash continuous-read bursts for the current owner.
- Prevents starvation with a burst limit and an idle-hold timeout.

Parameters:
- ADDR_W, 24, flash byte address width.
- MAX_BURST, 16, words delivered to the owner before it must yield while the other port is waiting; range 1..255.
- HOLD_CYCLES, 4, cycles the owner may keep its valid low before it loses the grant to a waiting port; range 1..255.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- r0_valid  in  1  port 0 request; held until r0_ready.
- r0_addr  in  ADDR_W  port 0 word address (bits [1:0] ignored).
- r0_ready  out  1  one-cycle completion pulse for port 0.
- r1_valid, r1_addr, r1_ready  same as port 0, for port 1.
- rdata  out  32  f_rdata broadcast; valid only in the cycle of rX_ready.
- f_valid  out  1  request to the flash engine.
- f_addr  out  ADDR_W  address to the flash engine.
- f_ready  in  1  engine word-done pulse (may also pulse spuriously during continuous read).
- f_rdata  in  32  engine read data.
- owner  out  1  current grant holder.
- busy  out  1  grant active.

Behaviour:
- Reset: state IDLE, owner=0, rr_last=1 (port 0 wins the first tie), burst_cnt=0, hold_cnt=0. All outputs are 0.
- States: IDLE, GRANT, SWITCH.
- IDLE:
  - If exactly one rX_valid is high: owner<=that port, go to GRANT next cycle.
  - If both are high: owner<=!rr_last.
  - Arbitration latency is 1 cycle. f_valid stays 0 while in IDLE.
- GRANT:
  - f_valid = owner valid && !f_ready. f_addr = owner addr.
  - rX_ready = f_ready && f_valid_q && owner==X && rX_valid, where f_valid_q is f_valid registered.
  - Stray f_ready (owner valid low, or in IDLE/SWITCH) is dropped and never forwarded.
  - On each forwarded ready: burst_cnt<=burst_cnt+1, saturating at MAX_BURST.
  - hold_cnt increments each cycle the owner valid is low; clears when the owner valid is high.
- Yield conditions (GRANT -> SWITCH), only when the other port's valid is high:
  - (a) a forwarded ready occurs with burst_cnt==MAX_BURST-1; or
  - (b) hold_cnt==HOLD_CYCLES-1 with owner valid still low.
- If the other port is not requesting, the owner keeps the grant indefinitely. burst_cnt saturates; no yield.
- GRANT -> IDLE: hold_cnt reaches HOLD_CYCLES with both valids low. rr_last<=owner.
- SWITCH (exactly 1 cycle):
  - f_valid=0; owner<=!owner, rr_last<=old owner, burst_cnt<=0, hold_cnt<=0; then go to GRANT.
  - The new address forces the engine to restart its command sequence.
- Simultaneous events:
  - Owner drops valid in the same cycle as a yield condition: the yield wins.
  - Forwarded ready and yield in the same cycle: the ready is forwarded, then the switch happens.
- Owner abandons mid-word (valid low before f_ready): no ready is forwarded. That word counts as nothing.
- resetn low mid-operation: immediate return to reset state next edge; f_valid=0.
- Never both r0_ready and r1_ready in the same cycle; at most one port sees f_valid effects.

Optional Feature:
- Macro: CTRLSOC_FLASH_ARB_STATS_EN.
- When defined:
  - Per-port 16-bit saturating counters stat_words0/1 (forwarded readies) and stat_wait0/1 (cycles with rX_valid high while not owner, or while in SWITCH).
  - Extra input stat_clr (synchronous clear) and outputs stat_words0, stat_words1, stat_wait0, stat_wait1, each 16 bits.
  - Counters saturate at 16'hFFFF. They clear on reset or stat_clr; stat_clr wins over an increment in the same cycle.
- When undefined: the ports still exist; outputs are tied to 0 and stat_clr is ignored.

Decomposition:
- Package ctrlsoc_flash_arb_pkg: state enum (IDLE, GRANT, SWITCH), OWNER_CPU=0 / OWNER_DMA=1, STAT_W=16.
- Sub-module ctrlsoc_flash_arb_satcnt (width-parameterised saturating counter with clear/inc), instantiated 4x under the stats macro.

Test Plan:
- Reset, then r0_valid with addr 0x100000 alone -> grant next cycle, f_addr=0x100000. r0_ready mirrors f_ready; rdata=f_rdata. r1_ready never asserts.
- Both valid in the same cycle after reset -> owner=0 first. After port 0 idles 4 cycles -> SWITCH 1 cycle with f_valid=0, then owner=1.
- Port 0 streams sequential words 0x100000, 0x100004, ... while r1_valid is held high -> exactly 16 r0_readys, a 1-cycle SWITCH, then r1 is served. Once port 1 meets its own yield condition (16 words or a 4-cycle valid gap), the grant returns to port 0.
- Engine pulses f_ready while owner valid is low -> no rX_ready; burst_cnt unchanged.
- resetn low during GRANT mid-word -> next edge: f_valid=0, busy=0, owner=0; the pending ready is not forwarded.
- With STATS_EN: port 1 waits 20 cycles -> stat_wait1=20. stat_clr together with an increment -> 0. Forcing 70000 waits -> stat_wait1=0xFFFF.

Source files
------------

// File: rtl/ctrlsoc_flash_arb_pkg.sv
// ctrlsoc_flash_arb_pkg: arbiter states, owner encodings and statistics width
package ctrlsoc_flash_arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, SWITCH} state_t;
    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;
    localparam int STAT_W = 16;
endpackage

// File: rtl/ctrlsoc_flash_arb_satcnt.sv
// ctrlsoc_flash_arb_satcnt: saturating up-counter with synchronous clear
module ctrlsoc_flash_arb_satcnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        if (!resetn || clr) q <= '0;
        else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/ctrlsoc_flash_arb.sv
// ctrlsoc_flash_arb: two-port QSPI flash read arbiter; CTRLSOC_FLASH_ARB_STATS_EN enables statistics counters
module ctrlsoc_flash_arb
    import ctrlsoc_flash_arb_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int MAX_BURST   = 16,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              r0_valid,
    input  logic [ADDR_W-1:0] r0_addr,
    output logic              r0_ready,
    input  logic              r1_valid,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r1_ready,
    output logic [31:0]       rdata,
    output logic              f_valid,
    output logic [ADDR_W-1:0] f_addr,
    input  logic              f_ready,
    input  logic [31:0]       f_rdata,
    output logic              owner,
    output logic              busy,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_words0,
    output logic [STAT_W-1:0] stat_words1,
    output logic [STAT_W-1:0] stat_wait0,
    output logic [STAT_W-1:0] stat_wait1
);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] HOLD_MAX   = 8'(HOLD_CYCLES);

    state_t      state, state_n;
    logic        owner_n, rr_last, rr_last_n, f_valid_q;
    logic [7:0]  burst_cnt, burst_n, hold_cnt, hold_n;
    logic        in_grant, own_valid, oth_valid, fwd, yield;
    logic [ADDR_W-1:0] own_addr;

    assign in_grant  = state == GRANT;
    assign own_valid = owner ? r1_valid : r0_valid;
    assign oth_valid = owner ? r0_valid : r1_valid;
    assign own_addr  = owner ? r1_addr : r0_addr;
    assign f_valid   = in_grant && own_valid && !f_ready;
    assign f_addr    = in_grant ? own_addr : '0;
    // only a ready answering a word the engine actually saw requested is forwarded
    assign fwd       = in_grant && f_ready && f_valid_q && own_valid;
    assign r0_ready  = fwd && owner == OWNER_CPU;
    assign r1_ready  = fwd && owner == OWNER_DMA;
    assign rdata     = fwd ? f_rdata : '0;
    assign busy      = state != IDLE;
    assign yield     = oth_valid && ((fwd && burst_cnt >= BURST_LAST) ||
                                     (!own_valid && hold_cnt >= HOLD_LAST));

    always_comb begin
        state_n   = state;
        owner_n   = owner;
        rr_last_n = rr_last;
        burst_n   = burst_cnt;
        hold_n    = hold_cnt;
        case (state)
            IDLE: if (r0_valid || r1_valid) begin
                state_n = GRANT;
                owner_n = (r0_valid && r1_valid) ? !rr_last : r1_valid;
                burst_n = '0;
                hold_n  = '0;
            end
            GRANT: begin
                burst_n = (fwd && burst_cnt != BURST_MAX) ? burst_cnt + 1'b1 : burst_cnt;
                hold_n  = own_valid ? 8'd0 : (hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + 1'b1);
                if (yield) state_n = SWITCH;
                else if (!r0_valid && !r1_valid && hold_cnt == HOLD_MAX) begin
                    state_n   = IDLE;
                    rr_last_n = owner;
                end
            end
            SWITCH: begin
                state_n   = GRANT;
                owner_n   = !owner;
                rr_last_n = owner;
                burst_n   = '0;
                hold_n    = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (!resetn) begin
            state     <= IDLE;
            owner     <= OWNER_CPU;
            rr_last   <= 1'b1;
            burst_cnt <= '0;
            hold_cnt  <= '0;
            f_valid_q <= 1'b0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rr_last   <= rr_last_n;
            burst_cnt <= burst_n;
            hold_cnt  <= hold_n;
            f_valid_q <= f_valid;
        end

`ifdef CTRLSOC_FLASH_ARB_STATS_EN
    logic wait0, wait1;
    assign wait0 = r0_valid && (state != GRANT || owner != OWNER_CPU);
    assign wait1 = r1_valid && (state != GRANT || owner != OWNER_DMA);
    ctrlsoc_flash_arb_satcnt #(.W(STAT_W)) u_words0 (.clk, .resetn, .clr(stat_clr), .inc(r0_ready), .q(stat_words0));
    ctrlsoc_flash_arb_satcnt #(.W(STAT_W)) u_words1 (.clk, .resetn, .clr(stat_clr), .inc(r1_ready), .q(stat_words1));
    ctrlsoc_flash_arb_satcnt #(.W(STAT_W)) u_wait0  (.clk, .resetn, .clr(stat_clr), .inc(wait0), .q(stat_wait0));
    ctrlsoc_flash_arb_satcnt #(.W(STAT_W)) u_wait1  (.clk, .resetn, .clr(stat_clr), .inc(wait1), .q(stat_wait1));
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_words0 = '0;
    assign stat_words1 = '0;
    assign stat_wait0  = '0;
    assign stat_wait1  = '0;
`endif
endmodule
